// File: rtl/fir_mac_sequencer.sv
// ============================================================================
// Module   : fir_mac_sequencer
// Function : Control sequencer for a time-multiplexed single-MAC FIR datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_mac_sequencer #(
  parameter int TAPS   = 32,
  parameter int ADDR_W = 5,
  parameter int PIPE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] co_addr,
  output logic              acc_clr,
  output logic              add_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              filled
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_LAST       = ADDR_W'(TAPS - 1);
  localparam int                c_DRAIN_INT  = (PIPE == 0) ? 0 : PIPE - 1;
  localparam logic [1:0]        c_DRAIN_LAST = 2'(c_DRAIN_INT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_filled;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_k;
  logic [1:0]        r_drain;

  logic              w_accept;
  logic              w_tap_last;
  logic [ADDR_W-1:0] w_wr_next;
  logic [ADDR_W-1:0] w_rd_next;

  assign w_accept   = in_valid & r_in_ready;
  assign w_tap_last = (r_k == c_LAST);
  // Explicit wrap at TAPS so non-power-of-two tap counts stay inside the ring.
  assign w_wr_next  = (r_wr_addr == c_LAST) ? '0 : r_wr_addr + 1'b1;
  assign w_rd_next  = (r_rd_addr == '0) ? c_LAST : r_rd_addr - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MAC;
      S_MAC:   if (w_tap_last) w_state_nxt = (PIPE == 0) ? S_HOLD : S_DRAIN;
      S_DRAIN: if (r_drain == c_DRAIN_LAST) w_state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags follow the next state, so they are registered yet track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_filled    <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_k         <= '0;
      r_drain     <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_HOLD);
      if (w_accept) begin
        r_wr_addr <= w_wr_next;
        r_rd_addr <= r_wr_addr;
        r_k       <= '0;
        if (r_wr_addr == c_LAST) r_filled <= 1'b1;
      end else if (r_state == S_MAC && !w_tap_last) begin
        r_k       <= r_k + 1'b1;
        r_rd_addr <= w_rd_next;
      end
      if (r_state == S_MAC) begin
        r_drain <= '0;
      end else if (r_state == S_DRAIN) begin
        r_drain <= r_drain + 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign wr_en     = w_accept;
  assign wr_addr   = r_wr_addr;
  assign rd_addr   = r_rd_addr;
  assign co_addr   = r_k;
  assign add_en    = (r_state == S_MAC);
  assign acc_clr   = (r_state == S_MAC) && (r_k == '0);
  assign out_valid = r_out_valid;
  assign filled    = r_filled;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
// ============================================================================
// Module   : tb_fir_mac_sequencer
// Function : Directed self-checking bench for fir_mac_sequencer (default and small config).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, wr_en, acc_clr, add_en, out_valid, filled;
  logic [4:0] wr_addr, rd_addr, co_addr;

  logic       in_valid5 = 1'b0;
  logic       out_ready5 = 1'b1;
  logic       in_ready5, wr_en5, acc_clr5, add_en5, out_valid5, filled5;
  logic [2:0] wr_addr5, rd_addr5, co_addr5;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.TAPS(32), .ADDR_W(5), .PIPE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .co_addr(co_addr),
    .acc_clr(acc_clr), .add_en(add_en), .out_valid(out_valid),
    .out_ready(out_ready), .filled(filled)
  );

  fir_mac_sequencer #(.TAPS(5), .ADDR_W(3), .PIPE(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .wr_en(wr_en5), .wr_addr(wr_addr5), .rd_addr(rd_addr5), .co_addr(co_addr5),
    .acc_clr(acc_clr5), .add_en(add_en5), .out_valid(out_valid5),
    .out_ready(out_ready5), .filled(filled5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready;
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
  endtask

  // One full 32-tap sample; returns just after the edge where out_valid rises.
  task automatic run32(input int slot, input bit exp_filled);
    wait_in_ready();
    in_valid = 1'b1;
    #1;
    chk("wr_en", 32'(wr_en), 1);
    chk("wr_addr", 32'(wr_addr), 32'(slot));
    tick();
    in_valid = 1'b0;
    chk("in_ready_busy", 32'(in_ready), 0);
    chk("filled", 32'(filled), 32'(exp_filled));
    for (int k = 0; k < 32; k++) begin
      chk("add_en", 32'(add_en), 1);
      chk("co_addr", 32'(co_addr), 32'(k));
      chk("rd_addr", 32'(rd_addr), 32'((slot - k + 32) % 32));
      chk("acc_clr", 32'(acc_clr), 32'(k == 0));
      chk("out_valid_mac", 32'(out_valid), 0);
      chk("wr_en_busy", 32'(wr_en), 0);
      tick();
    end
    chk("add_en_drain", 32'(add_en), 0);
    chk("out_valid_drain", 32'(out_valid), 0);
    chk("co_addr_drain", 32'(co_addr), 31);
    tick();
    chk("out_valid", 32'(out_valid), 1);
    chk("in_ready_hold", 32'(in_ready), 0);
  endtask

  task automatic run5(input int slot);
    int n = 0;
    while (!in_ready5 && n < 50) begin
      tick();
      n++;
    end
    chk("t5_in_ready_wait", 32'(in_ready5), 1);
    in_valid5 = 1'b1;
    #1;
    chk("t5_wr_en", 32'(wr_en5), 1);
    chk("t5_wr_addr", 32'(wr_addr5), 32'(slot));
    tick();
    in_valid5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t5_add_en", 32'(add_en5), 1);
      chk("t5_co_addr", 32'(co_addr5), 32'(k));
      chk("t5_rd_addr", 32'(rd_addr5), 32'((slot - k + 5) % 5));
      chk("t5_acc_clr", 32'(acc_clr5), 32'(k == 0));
      chk("t5_out_valid_mac", 32'(out_valid5), 0);
      tick();
    end
    chk("t5_out_valid", 32'(out_valid5), 1);
    chk("t5_add_en_hold", 32'(add_en5), 0);
    tick();
    chk("t5_out_valid_clr", 32'(out_valid5), 0);
    chk("t5_in_ready_back", 32'(in_ready5), 1);
  endtask

  initial begin
    // Reset held for three cycles: every output low
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_add_en", 32'(add_en), 0);
      chk("rst_acc_clr", 32'(acc_clr), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_filled", 32'(filled), 0);
      chk("rst_addrs", 32'({wr_addr, rd_addr, co_addr}), 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre", 32'(in_ready), 0);
    tick();
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_wr_addr", 32'(wr_addr), 0);
    chk("rel_filled", 32'(filled), 0);

    // Single sample, downstream always ready
    out_ready = 1'b1;
    run32(0, 1'b0);
    tick();
    chk("t2_out_valid_1cyc", 32'(out_valid), 0);
    chk("t2_in_ready_back", 32'(in_ready), 1);

    // Backpressure with upstream pushing during HOLD
    out_ready = 1'b0;
    run32(1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_out_valid_held", 32'(out_valid), 1);
      chk("t3_in_ready", 32'(in_ready), 0);
      chk("t3_add_en", 32'(add_en), 0);
      chk("t3_wr_en", 32'(wr_en), 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3_out_valid_rel", 32'(out_valid), 0);
    chk("t3_in_ready_rel", 32'(in_ready), 1);
    tick();
    chk("t3_out_valid_idle", 32'(out_valid), 0);
    chk("t3_wr_addr", 32'(wr_addr), 2);

    // Fresh reset, then 33 back-to-back samples to fill and wrap
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 33; i++) begin
      run32(i % 32, i >= 31);
      tick();
    end
    chk("t4_wr_addr", 32'(wr_addr), 1);

    // Reset pulse in the middle of a MAC run
    wait_in_ready();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t6_k10", 32'(co_addr), 10);
    rst_n = 1'b0;
    #1;
    chk("t6_add_en_async", 32'(add_en), 0);
    chk("t6_out_valid_async", 32'(out_valid), 0);
    chk("t6_filled_async", 32'(filled), 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("t6_no_result", 32'(out_valid | add_en), 0);
    end
    chk("t6_wr_addr", 32'(wr_addr), 0);
    run32(0, 1'b0);
    tick();
    chk("t6_out_valid_clr", 32'(out_valid), 0);

    // Small config: TAPS=5, PIPE=0, seven samples
    for (int i = 0; i < 7; i++) begin
      run5(i % 5);
    end
    chk("t5_filled", 32'(filled5), 1);
    chk("t5_wr_addr_end", 32'(wr_addr5), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
